// File: rtl/fft_output_reorder_pkg.sv
// Shared FFT constants and the radix-4 digit-reverse helper, also used by the
// input commutator.
package fft_output_reorder_pkg;

  localparam int FFT_DATA_W   = 32;
  localparam int FFT_N_POINTS = 16;
  localparam int DIGIT_W      = 2;
  localparam int IDX_W        = 2 * DIGIT_W;

  // Swap the two radix-4 digits of a 4-bit index: 4a+b -> 4b+a.
  function automatic logic [IDX_W-1:0] digit_rev(input logic [IDX_W-1:0] idx);
    return {idx[DIGIT_W-1:0], idx[IDX_W-1:DIGIT_W]};
  endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// One 16-entry complex sample bank: synchronous write port, asynchronous read port.
module fft_pingpong_bank
  import fft_output_reorder_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [2*DATA_W-1:0]   wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [2*DATA_W-1:0]   rdata
);

  logic [2*DATA_W-1:0] mem [FFT_N_POINTS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_output_reorder.sv
// Converts digit-reversed radix-4 FFT output frames into natural bin order
// using two ping-pong banks written with swapped digits and read sequentially.
module fft_output_reorder
  import fft_output_reorder_pkg::*;
#(
  parameter int DATA_W   = FFT_DATA_W,
  parameter int N_POINTS = FFT_N_POINTS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_real,
  input  logic signed [DATA_W-1:0]  in_im,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_real,
  output logic signed [DATA_W-1:0]  out_im,
  output logic [IDX_W-1:0]          out_index,
  output logic                      out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  logic [IDX_W-1:0]    wcnt;
  logic [IDX_W-1:0]    rcnt;
  logic                wbank;
  logic                rbank;
  logic [1:0]          full;
  logic                in_fire;
  logic                out_fire;
  logic                in_done;
  logic                out_done;
  logic [1:0]          bank_we;
  logic [2*DATA_W-1:0] bank_rdata [2];
  logic [2*DATA_W-1:0] rd_sel;

  assign in_ready  = ~full[wbank];
  assign out_valid = full[rbank];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign in_done   = in_fire & (wcnt == LAST_IDX);
  assign out_done  = out_fire & (rcnt == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt  <= '0;
      rcnt  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      full  <= '0;
    end else begin
      if (in_fire)  wcnt  <= wcnt + IDX_W'(1);
      if (in_done)  wbank <= ~wbank;
      if (out_fire) rcnt  <= rcnt + IDX_W'(1);
      if (out_done) rbank <= ~rbank;
      // A fill and a drain can finish together; they always target different banks.
      for (int unsigned b = 0; b < 2; b++) begin
        if (in_done && (wbank == 1'(b)))       full[b] <= 1'b1;
        else if (out_done && (rbank == 1'(b))) full[b] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign bank_we[g] = in_fire & (wbank == 1'(g));

    fft_pingpong_bank #(
      .DATA_W(DATA_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (digit_rev(wcnt)),
      .wdata ({in_real, in_im}),
      .raddr (rcnt),
      .rdata (bank_rdata[g])
    );
  end

  assign rd_sel    = rbank ? bank_rdata[1] : bank_rdata[0];
  assign out_real  = out_valid ? rd_sel[2*DATA_W-1:DATA_W] : '0;
  assign out_im    = out_valid ? rd_sel[DATA_W-1:0]        : '0;
  assign out_index = rcnt;
  assign out_last  = out_valid & (rcnt == LAST_IDX);

endmodule

// File: tb/tb_fft_output_reorder.sv
// Randomised self-checking bench for fft_output_reorder against a frame-level
// reorder model (natural bin k takes input position 4*(k%4) + k/4).
module tb_fft_output_reorder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_real;
  logic [W-1:0] in_im;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_real;
  logic [W-1:0] out_im;
  logic [3:0]   out_index;
  logic         out_last;

  fft_output_reorder #(
    .DATA_W  (W),
    .N_POINTS(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_real  (in_real),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real (out_real),
    .out_im   (out_im),
    .out_index(out_index),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] src_re[$], src_im[$];
  logic [W-1:0] exp_re[$], exp_im[$];
  int           exp_k[$];
  logic [W-1:0] obs_re[$], obs_im[$];
  logic [W-1:0] fr_re[16], fr_im[16];
  int           fill = 0;
  int           fire_first, fire_last, fire_cnt;

  int seq[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  function automatic void model_accept(input logic [W-1:0] re, input logic [W-1:0] im);
    fr_re[fill] = re;
    fr_im[fill] = im;
    fill++;
    if (fill == 16) begin
      for (int k = 0; k < 16; k++) begin
        exp_re.push_back(fr_re[4*(k%4) + k/4]);
        exp_im.push_back(fr_im[4*(k%4) + k/4]);
        exp_k.push_back(k);
      end
      fill = 0;
    end
  endfunction

  function automatic void model_clear();
    exp_re.delete(); exp_im.delete(); exp_k.delete();
    src_re.delete(); src_im.delete();
    fill = 0;
  endfunction

  function automatic void push_frame(input int base);
    for (int n = 0; n < 16; n++) begin
      src_re.push_back(32'(base + n));
      src_im.push_back(32'(-(base + n)));
    end
  endfunction

  // vmode: 0 = always offer, 1 = random offer.
  // rmode: 0 = ready high, 1 = random, 2 = toggle 1,0,..., 3 = ready low.
  task automatic run_traffic(input string name, input int vmode, input int rmode,
                             input int max_cycles);
    bit   done = 0;
    logic exp_rdy;
    fire_cnt = 0; fire_first = -1; fire_last = -1;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk);
      in_valid = (src_re.size() > 0) && (vmode == 0 || $urandom_range(1) == 1);
      if (src_re.size() > 0) begin
        in_real = src_re[0];
        in_im   = src_im[0];
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1));
        2:       out_ready = (c % 2 == 0);
        default: out_ready = 1'b0;
      endcase
      #1;
      checks++;
      if (out_valid !== (exp_re.size() > 0)) begin
        errors++;
        $display("FAIL %s out_valid cycle %0d: got %b want %b", name, c, out_valid, exp_re.size() > 0);
      end
      exp_rdy = ((exp_re.size() + 15) / 16) < 2;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s in_ready cycle %0d: got %b want %b", name, c, in_ready, exp_rdy);
      end
      if (exp_re.size() > 0) begin
        checks++;
        if (out_real !== exp_re[0] || out_im !== exp_im[0] ||
            out_index !== 4'(exp_k[0]) || out_last !== (exp_k[0] == 15)) begin
          errors++;
          $display("FAIL %s output cycle %0d: got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b",
                   name, c, out_real, out_im, out_index, out_last,
                   exp_re[0], exp_im[0], exp_k[0], exp_k[0] == 15);
        end
      end
      if (out_valid && out_ready && exp_re.size() > 0) begin
        obs_re.push_back(out_real);
        obs_im.push_back(out_im);
        void'(exp_re.pop_front()); void'(exp_im.pop_front()); void'(exp_k.pop_front());
        if (fire_first < 0) fire_first = c;
        fire_last = c;
        fire_cnt++;
      end
      if (in_valid && in_ready) model_accept(src_re.pop_front(), src_im.pop_front());
      if (rmode != 3 && src_re.size() == 0 && exp_re.size() == 0 && fill == 0) done = 1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (rmode != 3) begin
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL %s drain_timeout: got pending=%0d want 0", name, exp_re.size());
      end
    end
  endtask

  task automatic check_seq(input string name, input int frame, input int base);
    for (int i = 0; i < 16 && (16*frame + i) < obs_re.size(); i++) begin
      checks++;
      if (obs_re[16*frame+i] !== 32'(base + seq[i]) || obs_im[16*frame+i] !== 32'(-(base + seq[i]))) begin
        errors++;
        $display("FAIL %s seq[%0d]: got re=%0d im=%0d want re=%0d im=%0d", name, 16*frame+i,
                 $signed(obs_re[16*frame+i]), $signed(obs_im[16*frame+i]), base + seq[i], -(base + seq[i]));
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 4'd0 ||
        out_last !== 1'b0 || out_real !== '0 || out_im !== '0) begin
      errors++;
      $display("FAIL %s reset_outputs: got valid=%b ready=%b idx=%0d last=%b re=%h im=%h want 0 1 0 0 0 0",
               name, out_valid, in_ready, out_index, out_last, out_real, out_im);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_single_frame();
    obs_re.delete(); obs_im.delete();
    push_frame(0);
    run_traffic("single", 0, 0, 200);
    checks++;
    if (obs_re.size() !== 16) begin
      errors++;
      $display("FAIL single count: got %0d want 16", obs_re.size());
    end
    check_seq("single", 0, 0);
  endtask

  task automatic test_back_to_back();
    obs_re.delete(); obs_im.delete();
    push_frame(0);
    push_frame(100);
    run_traffic("b2b", 0, 0, 200);
    checks++;
    if (fire_cnt !== 32 || fire_last - fire_first !== 31) begin
      errors++;
      $display("FAIL b2b gapless: got %0d beats over %0d cycles want 32 over 32",
               fire_cnt, fire_last - fire_first + 1);
    end
    check_seq("b2b", 0, 0);
    check_seq("b2b", 1, 100);
  endtask

  task automatic test_backpressure();
    obs_re.delete(); obs_im.delete();
    push_frame(0); push_frame(100); push_frame(200);
    run_traffic("bp_hold", 0, 3, 60);
    checks++;
    if (src_re.size() !== 16 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: got unaccepted=%0d in_ready=%b want 16 0", src_re.size(), in_ready);
    end
    run_traffic("bp_drain", 0, 0, 300);
    checks++;
    if (obs_re.size() !== 48) begin
      errors++;
      $display("FAIL bp count: got %0d want 48", obs_re.size());
    end
    for (int f = 0; f < 3; f++) check_seq("bp", f, 100*f);
  endtask

  task automatic test_stall_toggle();
    obs_re.delete(); obs_im.delete();
    push_frame(0);
    run_traffic("toggle", 0, 2, 200);
    check_seq("toggle", 0, 0);
  endtask

  task automatic test_mid_frame_reset();
    obs_re.delete(); obs_im.delete();
    push_frame(0);
    for (int n = 0; n < 7; n++) begin
      src_re.push_back(32'(50 + n));
      src_im.push_back(32'(-(50 + n)));
    end
    run_traffic("pre_reset", 0, 3, 23);
    checks++;
    if (out_valid !== 1'b1 || src_re.size() !== 0) begin
      errors++;
      $display("FAIL pre_reset state: got valid=%b left=%0d want 1 0", out_valid, src_re.size());
    end
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    push_frame(0);
    run_traffic("post_reset", 0, 0, 200);
    check_seq("post_reset", 0, 0);
  endtask

  task automatic test_extreme_values();
    obs_re.delete(); obs_im.delete();
    push_frame(0);
    src_re[1] = 32'h8000_0000;
    src_im[1] = 32'h7FFF_FFFF;
    run_traffic("extreme", 0, 0, 200);
    checks++;
    if (obs_re.size() < 5 || obs_re[4] !== 32'h8000_0000 || obs_im[4] !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL extreme bin4: got re=%h im=%h want 80000000 7fffffff",
               obs_re.size() > 4 ? obs_re[4] : 32'h0, obs_im.size() > 4 ? obs_im[4] : 32'h0);
    end
  endtask

  task automatic test_random();
    obs_re.delete(); obs_im.delete();
    for (int i = 0; i < 64; i++) begin
      src_re.push_back($urandom);
      src_im.push_back($urandom);
    end
    run_traffic("random", 1, 1, 2000);
    checks++;
    if (obs_re.size() !== 64) begin
      errors++;
      $display("FAIL random count: got %0d want 64", obs_re.size());
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_real   = '0;
    in_im     = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_stall_toggle();
    test_mid_frame_reset();
    test_extreme_values();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_output_reorder.md
FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

Interface
REQ-001 Parameter DATA_W, default 32, width of each signed real/imag sample.
REQ-002 Parameter N_POINTS, default 16, frame length; fixed at 16 (two radix-4 digits).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_real/in_im carry a sample from the last butterfly stage.
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 in_real, in_im  input  DATA_W each  signed sample, digit-reversed frame order.
REQ-008 out_valid  output  1  out_real/out_im/out_index/out_last are valid.
REQ-009 out_ready  input  1  downstream accepts the output sample this cycle.
REQ-010 out_real, out_im  output  DATA_W each  signed sample, natural frequency order.
REQ-011 out_index  output  4  bin number k (0..15) of the current output sample.
REQ-012 out_last  output  1  high with out_valid when out_index = 15.

Function
REQ-013 An input beat is accepted when in_valid and in_ready are both high; an output beat completes when out_valid and out_ready are both high.
REQ-014 A 4-bit write counter wcnt counts accepted input beats 0..15 and wraps to 0 after 15.
REQ-015 Accepted beat at position wcnt = 4a+b is stored at address 4b+a (2-bit digit swap) of the current write bank.
REQ-016 Storage is two banks (ping-pong) of 16 complex entries; the write bank toggles when beat 15 is accepted.
REQ-017 Each bank has a full flag: set when its beat 15 is accepted; cleared when its output beat 15 completes.
REQ-018 in_ready = NOT full[write bank]; with both banks full, in_ready is low and input is stalled without loss.
REQ-019 Read side: while full[read bank] is set, out_valid is high and the block presents entry rcnt of the read bank, with out_index = rcnt.
REQ-020 rcnt increments on each completed output beat and wraps 15 -> 0; at the wrap the read bank toggles.
REQ-021 Output data holds stable while out_valid is high and out_ready is low.
REQ-022 Latency: out_valid rises in the cycle after input beat 15 of a frame is accepted, provided the read bank is free.
REQ-023 If the last output beat of bank X and the last input beat into bank Y complete in the same cycle, both flag updates take effect in that cycle.
REQ-024 With out_ready held high, output sustains one sample per clock with no bubbles between back-to-back frames.
REQ-025 No arithmetic is performed; samples pass bit-exact, sign preserved.

Reset
REQ-026 When reset is low: wcnt = 0, rcnt = 0, write bank = 0, read bank = 0, both full flags = 0.
REQ-027 Output values during reset: out_valid = 0, in_ready = 1, out_index = 0, out_last = 0, out_real = 0, out_im = 0.
REQ-028 Reset asserted mid-frame discards every partial and complete frame; bank contents need not be cleared.

Structure
REQ-029 The shared FFT package holds DATA_W, N_POINTS, the 2-bit digit width, and a digit-reverse function for 4-bit indices. The input commutator uses the same function.
REQ-030 One sub-module, fft_pingpong_bank: a 16-entry, 2*DATA_W register array with one write port and one asynchronous read port, instantiated twice.

Verification
REQ-031 Frame in_real = n, in_im = -n (n = 0..15), out_ready held at 1 -> out_real sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15, imag parts negated, out_last only on the 16th beat.
REQ-032 Two back-to-back frames (values n, then 100+n) with out_ready = 1 -> 32 consecutive valid outputs with no gap; second frame gives 100,104,...,115.
REQ-033 out_ready = 0 while three frames are offered -> in_ready drops after beat 31 and stays low; release out_ready -> all 48 samples emerge in order, none lost.
REQ-034 out_ready toggled 1,0,1,0 during a frame -> out_real holds stable on stall cycles and the sequence of REQ-031 is unchanged.
REQ-035 reset pulsed low after 7 input beats -> out_valid = 0 and in_ready = 1 immediately; the next full frame 0..15 yields the REQ-031 sequence.
REQ-036 in_real = 0x80000000 and in_im = 0x7FFFFFFF at n = 1 -> same values appear bit-exact at out_index 4.
